rr_arbiter8: RTL
================

Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Each cycle it searches the request vector circularly with an internal priority encoder.
- It grants one requester, one-hot plus a binary index, and holds the grant until release or timeout.
- It sits in front of any shared datapath that needs the encoded index of the current owner.

Parameters:
N, 8, number of requesters (fixed at 8 for this revision)
W, 3, width of grant index, log2(N)
MAX_HOLD, 16, max consecutive grant cycles before forced revoke when others are waiting (range 2..255)

Ports:
clk  input  1  clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
req  input  N  request vector; bit k high = requester k wants the resource
gnt  output  N  one-hot grant, registered; all zero when idle
gnt_id  output  W  binary index of granted requester, valid when gnt_vld=1
gnt_vld  output  1  a grant is active
timeout  output  1  single-cycle pulse on the cycle gnt drops because MAX_HOLD expired

Behaviour:
- Reset (rst_n low, async):
  - gnt=0, gnt_id=0, gnt_vld=0, timeout=0.
  - ptr=0, so requester 0 has top priority.
  - hold counter=0, state=IDLE.
  - Asserting reset mid-grant drops the grant immediately; no release handshake.
- State IDLE:
  - If req!=0, select the first set bit at index ptr, ptr+1, …, wrapping 7→0.
  - Next edge: load gnt=onehot(winner), gnt_id=winner, gnt_vld=1, counter=1, state=GRANT.
  - Latency is 1 clock from req sampled high to gnt_vld high.
  - If req==0, remain IDLE with outputs zero.
- State GRANT, normal release:
  - If req[gnt_id] is sampled low, next edge clears gnt/gnt_vld.
  - ptr=(gnt_id+1) mod 8, with natural 3-bit wrap.
  - state=IDLE.
- State GRANT, timeout:
  - If req[gnt_id] is high, counter==MAX_HOLD, and any other req bit is high, next edge clears gnt/gnt_vld.
  - timeout=1 for that one cycle, ptr=(gnt_id+1) mod 8, state=IDLE.
- State GRANT, otherwise:
  - Counter increments, saturating at MAX_HOLD.
  - A lone requester keeps the grant indefinitely; the counter stays at MAX_HOLD.
- Turnaround:
  - Every grant change passes through exactly one IDLE cycle with gnt=0, so the minimum gap between grants is 1 cycle.
  - A grant is never reissued without that gap, even to the same requester.
- Fairness:
  - A requester that keeps req high after release or revoke is lowest priority in the next arbitration.
  - Any continuously requesting line is granted within 7 grants.
- Request changes:
  - New or dropped requests from non-owners during GRANT have no effect until the next IDLE cycle.
  - Requests are sampled only at clock edges; no combinational path from req to gnt.
- Output invariants:
  - gnt is always zero or one-hot.
  - gnt_vld == |gnt.
  - gnt_id is held at its last value when gnt_vld=0.
- Simultaneous events:
  - Owner drop and timeout in the same cycle count as a normal release: timeout stays 0.
  - req==0 in IDLE leaves ptr unchanged.

Test Plan:
1. Reset: rst_n=0 with req=8'hFF, then release at posedge → gnt=00000000 during reset; one cycle after release gnt=00000001, gnt_id=000, gnt_vld=1.
2. Single request: req=8'b0010_0000 from idle → next cycle gnt=00100000, gnt_id=101. Drop req → gnt=0 next cycle, ptr=110.
3. Round-robin wrap: req=8'b1000_0001 held, each owner drops req for one cycle after 2 cycles of grant → grant order 000,111,000,111; one zero-gnt cycle between each.
4. Timeout (MAX_HOLD=4): req=8'b0000_0101 held constant → requester 0 holds 4 cycles, then timeout=1 pulse with gnt=0. Next cycle gnt_id=010, after 4 more cycles timeout again and gnt_id=000.
5. Lone holder (MAX_HOLD=4): req=8'b0100_0000 held 20 cycles → gnt_id=110 for all 20 cycles, timeout never asserts.
6. Async reset mid-grant: grant active on id 011, pulse rst_n low between edges → gnt clears without waiting for clk. After release with req=8'b0000_1000, grant returns to 011 one cycle later (ptr reset to 0).

Source files
------------

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// The master modport belongs to the requester side; the slave modport belongs to the arbiter.
interface rr_arbiter8_if #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) ();
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_id;
    logic         gnt_vld;
    logic         timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_vld,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_vld,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, a binary owner index and a hold-time limit.
// Every grant change passes through one idle cycle; the owner is revoked after MAX_HOLD cycles when others wait.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter8_if.slave  bus
);
    localparam int unsigned N  = 8;
    localparam int unsigned W  = 3;
    localparam int unsigned CW = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [W-1:0]   gnt_id_q, gnt_id_d;
    logic           gnt_vld_q, gnt_vld_d;
    logic           timeout_q, timeout_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [W-1:0]   idx;
    logic [W-1:0]   win_id;
    logic           win_vld;
    logic           others_c;
    logic           owner_req_c;
    logic           hold_max_c;

    // Circular priority search starting at ptr; scanning downward lets the smallest offset win.
    always_comb begin
        idx     = '0;
        win_id  = ptr_q;
        win_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr_q + W'(i);
            if (bus.req[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    assign owner_req_c = bus.req[gnt_id_q];
    assign others_c    = |(bus.req & ~gnt_q);
    assign hold_max_c  = (cnt_q == CW'(MAX_HOLD));

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_vld_d = gnt_vld_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
                cnt_d     = '0;
                if (win_vld) begin
                    gnt_d     = N'(1) << win_id;
                    gnt_id_d  = win_id;
                    gnt_vld_d = 1'b1;
                    cnt_d     = CW'(1);
                    state_d   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A dropped owner request takes precedence over an expiring hold timer.
                if (!owner_req_c || (hold_max_c && others_c)) begin
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    timeout_d = owner_req_c;
                    ptr_d     = gnt_id_q + W'(1);
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (!hold_max_c) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_vld_q <= gnt_vld_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign bus.timeout = timeout_q;
endmodule
